// File: rtl/inst_mem_port_if.sv
// inst_mem_port_if: fetch-request, RAM-bus and result signals of the
// instruction-side memory port, bundled for the port and its environment.
// Optional macro INST_MEM_FILL_EN adds the instruction-cache fill outputs.
interface inst_mem_port_if #(
  parameter int ADDR_W = 32
);
  logic              instEn;
  logic [ADDR_W-1:0] instAddr;
  logic              instDiscard;
  logic              mem_grant;
  logic [7:0]        ram_din;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_rd;
  logic              busy;
  logic              memInstOutEn;
  logic [31:0]       memInst;
`ifdef INST_MEM_FILL_EN
  logic              fill_en;
  logic [ADDR_W-1:0] fill_addr;
  logic [31:0]       fill_inst;

  modport master (
    output instEn, instAddr, instDiscard, mem_grant, ram_din,
    input  ram_addr, ram_rd, busy, memInstOutEn, memInst,
           fill_en, fill_addr, fill_inst
  );
  modport slave (
    input  instEn, instAddr, instDiscard, mem_grant, ram_din,
    output ram_addr, ram_rd, busy, memInstOutEn, memInst,
           fill_en, fill_addr, fill_inst
  );
`else
  modport master (
    output instEn, instAddr, instDiscard, mem_grant, ram_din,
    input  ram_addr, ram_rd, busy, memInstOutEn, memInst
  );
  modport slave (
    input  instEn, instAddr, instDiscard, mem_grant, ram_din,
    output ram_addr, ram_rd, busy, memInstOutEn, memInst
  );
`endif
endinterface

// File: rtl/inst_mem_port.sv
// inst_mem_port: fetches one 32-bit little-endian instruction word as four
// byte reads over the shared RAM bus, stalling while the arbiter withholds
// grant, and returns it as a one-cycle memInstOutEn/memInst pulse.
// An instEn+instDiscard while busy abandons the read and restarts at the new
// address. Optional macro INST_MEM_FILL_EN adds fill_en/fill_addr/fill_inst.
module inst_mem_port #(
  parameter int ADDR_W  = 32,
  parameter int RAM_LAT = 1   // 1 or 2
) (
  input  logic           clk,
  input  logic           rst,
  inst_mem_port_if.slave io_bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_base;
  logic [1:0]        r_issue_cnt;
  logic [2:0]        r_recv_cnt;
  logic [31:0]       r_buf;
  logic [31:0]       r_inst;

  logic       w_discard;
  logic       w_accept;
  logic       w_issue;
  logic       w_capture;
  logic [1:0] w_cap_idx;
  logic       w_pulse;
  logic [2:0] w_recv_next;
  logic       w_unused_lsb;

  // Discard only has meaning while a read is in flight; in IDLE it is a plain request.
  assign w_discard   = io_bus.instEn & io_bus.instDiscard & (r_state != S_IDLE);
  assign w_accept    = w_discard |
                       (io_bus.instEn & ((r_state == S_IDLE) | (r_state == S_DONE)));
  assign w_issue     = (r_state == S_ISSUE) & io_bus.mem_grant;
  assign w_pulse     = (r_state == S_DONE) & ~w_discard;
  assign w_recv_next = r_recv_cnt + {2'b00, w_capture};
  // The request is word-aligned, so the two low address bits are dropped.
  assign w_unused_lsb = ^io_bus.instAddr[1:0];

  // Byte-index tags travel alongside the RAM latency so each returning byte
  // lands in its own lane; a discard flushes them so stale bytes are ignored.
  genvar gi;
  generate
    for (gi = 0; gi < RAM_LAT; gi++) begin : g_tag
      logic       r_vld;
      logic [1:0] r_idx;
      if (gi == 0) begin : g_head
        // Tag the address issued this cycle with its byte index
        always_ff @(posedge clk) begin
          if (rst || w_discard) begin
            r_vld <= 1'b0;
            r_idx <= 2'd0;
          end else begin
            r_vld <= w_issue;
            r_idx <= r_issue_cnt;
          end
        end
      end else begin : g_body
        // Delay the tag by one more cycle of RAM latency
        always_ff @(posedge clk) begin
          if (rst || w_discard) begin
            r_vld <= 1'b0;
            r_idx <= 2'd0;
          end else begin
            r_vld <= g_tag[gi-1].r_vld;
            r_idx <= g_tag[gi-1].r_idx;
          end
        end
      end
    end
  endgenerate

  assign w_capture = g_tag[RAM_LAT-1].r_vld;
  assign w_cap_idx = g_tag[RAM_LAT-1].r_idx;

  // Request acceptance, byte issue and completion sequencing
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_base      <= '0;
      r_issue_cnt <= 2'd0;
      r_recv_cnt  <= 3'd0;
    end else if (w_accept) begin
      r_state     <= S_ISSUE;
      r_base      <= {io_bus.instAddr[ADDR_W-1:2], 2'b00};
      r_issue_cnt <= 2'd0;
      r_recv_cnt  <= 3'd0;
    end else begin
      r_recv_cnt <= w_recv_next;
      case (r_state)
        S_ISSUE: begin
          if (w_issue) begin
            r_issue_cnt <= r_issue_cnt + 2'd1;
            if (r_issue_cnt == 2'd3) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_recv_next == 3'd4) r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Steer each returning byte into its little-endian lane
  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf <= '0;
    end else if (w_capture) begin
      r_buf[{w_cap_idx, 3'b000} +: 8] <= io_bus.ram_din;
    end
  end

  // Hold the last delivered word between pulses; discarded reads never land here
  always_ff @(posedge clk) begin
    if (rst) begin
      r_inst <= '0;
    end else if (w_pulse) begin
      r_inst <= r_buf;
    end
  end

  assign io_bus.ram_rd       = w_issue;
  assign io_bus.ram_addr     = w_issue ? (r_base + ADDR_W'(r_issue_cnt)) : '0;
  assign io_bus.busy         = (r_state != S_IDLE);
  assign io_bus.memInstOutEn = w_pulse;
  assign io_bus.memInst      = w_pulse ? r_buf : r_inst;

`ifdef INST_MEM_FILL_EN
  assign io_bus.fill_en   = w_pulse;
  assign io_bus.fill_addr = w_pulse ? r_base : '0;
  assign io_bus.fill_inst = w_pulse ? r_buf : '0;
`endif

endmodule

// File: doc/inst_mem_port.md
Name: inst_mem_port

Overview:
- Instruction-side port of the memory controller, directly upstream of the fetch stage.
- Accepts a word fetch request (instEn/instAddr) from fetch and reads the 4 instruction bytes over the byte-wide RAM bus. Little-endian.
- Returns the assembled word as a one-cycle memInstOutEn/memInst pulse.
- Supports aborting an in-flight read (instDiscard) on branch mispredict, and yields the RAM bus whenever the arbiter withholds grant.

Parameters:
- ADDR_W, 32, width of instAddr and ram_addr.
- RAM_LAT, 1, RAM read latency in cycles; a byte appears on ram_din RAM_LAT cycles after its address is issued. Supported values: 1 and 2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- instEn  in  1  fetch request valid.
- instAddr  in  ADDR_W  word address of the request; bits [1:0] ignored (forced 0).
- instDiscard  in  1  abort the current read; only meaningful together with instEn=1.
- mem_grant  in  1  arbiter permits this port to issue a RAM address this cycle.
- ram_din  in  8  RAM read data.
- ram_addr  out  ADDR_W  RAM byte address.
- ram_rd  out  1  RAM read strobe; ram_addr is valid when ram_rd=1.
- busy  out  1  high from request acceptance until the result pulse (inclusive).
- memInstOutEn  out  1  one-cycle pulse: memInst is valid.
- memInst  out  32  assembled instruction, held stable until the next pulse.

Behaviour:
- Reset values: ram_rd=0, ram_addr=0, busy=0, memInstOutEn=0, memInst=0, state=IDLE, all counters 0.
  - Reset mid-read drops the read; no pulse follows.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE
  - instEn=1: latch base={instAddr[ADDR_W-1:2],2'b00}, clear issue_cnt and recv_cnt, set busy, go to ISSUE next cycle.
  - instDiscard is ignored in IDLE; a plain request is accepted.
- ISSUE
  - Each cycle with mem_grant=1: ram_rd=1, ram_addr=base+issue_cnt, then issue_cnt++.
  - mem_grant=0: ram_rd=0 and issue_cnt holds (stall). Bytes already issued are still captured.
  - After byte 3 is issued, go to DRAIN.
- Capture
  - A RAM_LAT-deep shift register tags returning bytes with their index.
  - Byte k is written into memInst_buf[8k+7:8k]; recv_cnt++.
- DRAIN
  - When recv_cnt reaches 4, go to DONE.
- DONE
  - Registered memInstOutEn=1 for exactly one cycle; memInst=memInst_buf; busy=1 this cycle; next state IDLE.
  - If instEn=1 in this DONE cycle, the new request is accepted as in IDLE (back-to-back), i.e. next state ISSUE.
- Latency with mem_grant held 1 and RAM_LAT=1:
  - Request accepted at cycle t; addresses issued t+1..t+4; bytes arrive t+2..t+5; memInstOutEn at t+6.
- Discard: instEn=1 and instDiscard=1 while in ISSUE, DRAIN or DONE.
  - Any pending pulse is suppressed. If the discard coincides with the DONE cycle, memInstOutEn is forced 0.
  - In-flight byte tags are invalidated, so late bytes are not captured.
  - The new address is latched and the FSM restarts in ISSUE next cycle.
- instEn=1 without instDiscard while in ISSUE or DRAIN is ignored. Fetch never issues it; the bench flags it as a protocol error.
- Address arithmetic: base+issue_cnt is ADDR_W-bit and wraps modulo 2^ADDR_W. The base is word-aligned, so there is no carry beyond bit 1 inside a word.
- memInst keeps its last value when not pulsing. A discarded read never updates memInst.

Optional Feature:
- Macro: INST_MEM_FILL_EN.
- Defined:
  - Adds outputs fill_en (1), fill_addr (ADDR_W) and fill_inst (32) for the instruction cache.
  - fill_en pulses in the same cycle as memInstOutEn, with fill_addr=base and fill_inst=memInst.
  - A discarded read never produces fill_en.
  - fill_en, fill_addr and fill_inst reset to 0.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Basic read: rst released, bytes at 0x100..0x103 = 13,05,10,00, instEn=1 with instAddr=0x100 at cycle 0, grant=1, RAM_LAT=1 -> ram_addr 0x100..0x103 on cycles 1-4, memInstOutEn=1 only at cycle 6, memInst=0x00100513.
- Grant stall: same request with mem_grant=0 on cycles 2-3 -> addresses 0x100, then a 2-cycle gap, then 0x101..0x103; pulse at cycle 8 with the same data.
- Discard mid-read: request 0x100, then at cycle 3 instEn=1, instDiscard=1, instAddr=0x200 (word 0xDEADBEEF) -> no pulse for 0x100; single pulse with memInst=0xDEADBEEF 6 cycles after the discard.
- Discard on the DONE cycle: discard to 0x300 in the same cycle the 0x100 pulse would fire -> memInstOutEn=0 that cycle; next pulse is 0x300's word.
- Reset mid-read at cycle 3 -> all outputs 0 the next cycle, no later pulse. Wrap: instAddr=0xFFFFFFFC -> ram_addr FFFFFFFC..FFFFFFFF.
- With INST_MEM_FILL_EN defined, basic read -> fill_en=1 at cycle 6 with fill_addr=0x100, fill_inst=0x00100513; discarded read -> fill_en never asserts.
